// File: rtl/cpu_controller.sv
// 8-phase instruction sequencer for the 8-bit accumulator CPU.
// A phase counter plus a sticky halt flag, decoded combinationally into memory/IR/PC/AC strobes.
module cpu_controller #(
    parameter int OPC_WIDTH = 3,
    parameter int PH_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic                 zero,
    output logic [PH_WIDTH-1:0]  phase,
    output logic                 sel,
    output logic                 rd,
    output logic                 ld_ir,
    output logic                 wr,
    output logic                 data_e,
    output logic                 inc_pc,
    output logic                 ld_pc,
    output logic                 ld_ac,
    output logic                 halt
);

    typedef enum logic [PH_WIDTH-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    localparam logic [OPC_WIDTH-1:0] OP_HLT = 3'd0;
    localparam logic [OPC_WIDTH-1:0] OP_SKZ = 3'd1;
    localparam logic [OPC_WIDTH-1:0] OP_ADD = 3'd2;
    localparam logic [OPC_WIDTH-1:0] OP_AND = 3'd3;
    localparam logic [OPC_WIDTH-1:0] OP_XOR = 3'd4;
    localparam logic [OPC_WIDTH-1:0] OP_LDA = 3'd5;
    localparam logic [OPC_WIDTH-1:0] OP_STO = 3'd6;
    localparam logic [OPC_WIDTH-1:0] OP_JMP = 3'd7;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   is_aluop;
    logic   is_hlt;

    assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_hlt   = (opcode == OP_HLT);
    assign phase    = phase_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // A HLT in phase 4 freezes the counter there instead of advancing.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (run && !halted_q) begin
            if (phase_q == PH_OP_ADDR && is_hlt) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        halt   = halted_q || (phase_q == PH_OP_ADDR && is_hlt);
        if (!halted_q) begin
            case (phase_q)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    inc_pc = 1'b1;
                end
                PH_OP_FETCH: begin
                    rd = is_aluop;
                end
                // Memory latches the store address here, so the AC must not drive yet.
                PH_ALU_OP: begin
                    rd     = is_aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                end
                PH_STORE: begin
                    rd     = is_aluop;
                    ld_ac  = is_aluop;
                    ld_pc  = (opcode == OP_JMP);
                    inc_pc = (opcode == OP_JMP);
                    wr     = (opcode == OP_STO);
                    data_e = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule
